nzcv_flag_reg: RTL and testbench
================================

# nzcv_flag_reg

Status-flag register stage for the prototype processor: computes N, Z, C and V from execute-stage results and holds them until commit. Its architectural flags feed the condition checker's 4-bit flag input (bit order `[3]=N, [2]=Z, [1]=C, [0]=V`). A forwarded view includes a not-yet-committed update, so back-to-back conditional instructions see correct flags. It also accepts direct masked flag writes (MSR-style) and counts committed updates.

## Interface

**Parameters**
- `DATA_W`, default 32: width of the execute result.
- `CNT_W`, default 8: width of the saturating update counter.

**Ports**
- `CLK`, in, 1: single system clock; all state updates on the rising edge.
- `RST_N`, in, 1: reset, asynchronous and active-low.
- `EX_VALID`, in, 1: the execute stage holds a valid instruction.
- `EX_SET_FLAGS`, in, 1: the instruction's S bit.
- `EX_COND_MATCH`, in, 1: condition-checker verdict for this instruction.
- `EX_OP_CLASS`, in, 2: update class.
  - 00 arithmetic: update NZCV.
  - 01 logical: update N, Z, C from the shifter; keep V.
  - 10 multiply: update N, Z; keep C, V.
  - 11 reserved: no update.
- `EX_RESULT`, in, DATA_W: ALU/multiplier result.
- `EX_ALU_C`, in, 1: ALU carry out.
- `EX_ALU_V`, in, 1: ALU overflow.
- `EX_SHIFT_C`, in, 1: shifter carry out.
- `STALL`, in, 1: pipeline hold.
- `FLUSH`, in, 1: kill in-flight work.
- `WR_VALID`, in, 1: direct flag write strobe.
- `WR_DATA`, in, 4: direct flag write value (NZCV).
- `WR_MASK`, in, 4: per-bit write enable for `WR_DATA`.
- `FLAG_OUT`, out, 4: committed NZCV, registered.
- `FLAG_FWD`, out, 4: pending NZCV if pending is full, else `FLAG_OUT`.
- `FLAGS_PENDING`, out, 1: pending stage full.
- `UPD_CNT`, out, CNT_W: count of committed flag updates, saturating.

## Operation

- **Pending-stage FSM.** States are EMPTY and FULL. The visible state is `FLAGS_PENDING`.
- **Accept condition:** `accept = EX_VALID & EX_SET_FLAGS & EX_COND_MATCH & (EX_OP_CLASS != 11) & !STALL & !FLUSH`.
- **Flag computation.**
  - N = `EX_RESULT[DATA_W-1]`.
  - Z = (`EX_RESULT` == 0).
  - C and V follow the op class.
  - "Keep" bits are taken from `FLAG_FWD`, never from `FLAG_OUT`.
- **EMPTY:**
  - `accept` → FULL, loading the computed flags into the pending register.
- **FULL:**
  - `FLUSH`: discard pending → EMPTY. `FLAG_OUT` is unchanged; the counter does not increment.
  - `STALL` without `FLUSH`: hold everything.
  - Otherwise commit pending to `FLAG_OUT` and increment `UPD_CNT`. Then:
    - `accept` → stay FULL with the new flags;
    - no `accept` → EMPTY.
- **Direct write.**
  - `WR_VALID` updates the `FLAG_OUT` bits where `WR_MASK=1`, regardless of `STALL`.
  - If a commit happens on the same edge, the write overrides the commit per bit.
  - A direct write does not increment `UPD_CNT`.
  - It does not alter a pending entry that stays pending.
- **Counter.** `UPD_CNT` saturates at 2^CNT_W−1 and is cleared only by reset.
- **Reset (asynchronous, `RST_N=0`):** `FLAG_OUT=0000`, pending EMPTY, pending data 0000, `FLAG_FWD=0000`, `FLAGS_PENDING=0`, `UPD_CNT=0`. Reset mid-update discards pending data.

## Timing

- **Update latency.** Accept at edge k gives `FLAG_FWD`/`FLAGS_PENDING` valid after edge k. `FLAG_OUT` updates at edge k+1 if that cycle has no `STALL` or `FLUSH`.
- **Registered outputs.** `FLAG_OUT` and `UPD_CNT` are registered. `FLAG_FWD` is a mux driven only by registers.
- **No input-to-output combinational paths.** This avoids a loop through the condition checker and `EX_COND_MATCH`.
- **Back-to-back accepts** (full throughput, one per cycle) are supported with no bubbles.
- **Signal priority:** `RST_N` > `FLUSH` > `STALL` > commit/accept. `WR_VALID` overrides the commit per bit.

## Structure

- **Shared package `cpu_flags_pkg`:**
  - flag bit indices `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`;
  - op-class constants `OPC_ARITH=2'b00`, `OPC_LOGIC=2'b01`, `OPC_MUL=2'b10`, `OPC_NONE=2'b11`.
- **Sub-module `nzcv_calc`** (combinational): inputs result, op class, carries and keep-flags; output next NZCV. The top level holds the FSM, registers and counter.

## Test plan

1. **Reset state.** Assert `RST_N=0` mid-cycle → all outputs 0 asynchronously. Release, then accept arithmetic result 0x00000000 with C=1, V=0 → `FLAG_FWD=0110` after the edge, `FLAG_OUT=0110` one edge later, `UPD_CNT=1`.
2. **Back-to-back forwarding.**
   - Cycle 0: arithmetic 0x80000000 with V=1 → pending 1001.
   - Cycle 1: logical 0x00000001 with `EX_SHIFT_C=1` → `FLAG_FWD=0011`, with V=1 kept from pending.
   - Result: `FLAG_OUT` sequence 1001 then 0011; `UPD_CNT` +2.
3. **Non-update cases.** `EX_COND_MATCH=0`, `EX_SET_FLAGS=0`, or `OP_CLASS=11` → no pending entry, no change to `FLAG_OUT` or `UPD_CNT`.
4. **Stall then flush.** Pending full with 0100 and `STALL=1` for 3 cycles → all outputs held. Then `FLUSH=1` → `FLAGS_PENDING=0`, `FLAG_OUT` unchanged, `UPD_CNT` unchanged.
5. **Direct-write collision.** Commit of pending 1110 on the same edge as `WR_VALID` with `WR_DATA=0001`, `WR_MASK=0011` → `FLAG_OUT=1101`.
6. **Counter saturation.** Use `CNT_W=2` and 5 consecutive committed updates → `UPD_CNT` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cpu_flags_pkg.sv
// Purpose: shared NZCV flag bit positions, op-class codes and pending-stage state type.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package cpu_flags_pkg;

    // Bit positions inside a 4-bit NZCV word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag-update class carried by each execute-stage instruction.
    localparam logic [1:0] OPC_ARITH = 2'b00;  // N Z C V
    localparam logic [1:0] OPC_LOGIC = 2'b01;  // N Z C(shifter), keep V
    localparam logic [1:0] OPC_MUL   = 2'b10;  // N Z, keep C V
    localparam logic [1:0] OPC_NONE  = 2'b11;  // no update

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;

    // Per-bit merge: bits with mask=1 take wr_dat, the rest keep base.
    function automatic logic [3:0] merge_masked(input logic [3:0] base,
                                                input logic [3:0] wr_dat,
                                                input logic [3:0] wr_mask);
        return (base & ~wr_mask) | (wr_dat & wr_mask);
    endfunction

endpackage

// File: rtl/nzcv_calc.sv
// Purpose: derives the next NZCV word from an execute result and its op class.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: result/op_class/alu_c/alu_v/shift_c from execute, keep_cv = current
//        forwarded {C,V} for classes that preserve them, next_flags = NZCV.
module nzcv_calc
    import cpu_flags_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] result,
    input  logic [1:0]        op_class,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              shift_c,
    input  logic [1:0]        keep_cv,
    output logic [3:0]        next_flags
);

    always_comb begin
        next_flags         = 4'b0000;
        next_flags[FLAG_N] = result[DATA_W-1];
        next_flags[FLAG_Z] = (result == '0);
        next_flags[FLAG_C] = keep_cv[1];
        next_flags[FLAG_V] = keep_cv[0];
        case (op_class)
            OPC_ARITH: begin
                next_flags[FLAG_C] = alu_c;
                next_flags[FLAG_V] = alu_v;
            end
            OPC_LOGIC: begin
                next_flags[FLAG_C] = shift_c;
            end
            default: begin
                // multiply keeps C and V; reserved never gets accepted
            end
        endcase
    end

endmodule

// File: rtl/nzcv_flag_reg.sv
// Purpose: one-entry pending stage plus committed NZCV register, masked direct writes, update counter.
// Latency: accept at edge k -> FLAG_FWD at k; FLAG_OUT at k+1 when that cycle is neither stalled nor flushed.
// Backpressure: STALL holds pending and counter (direct writes still land); FLUSH drops pending; 1 accept/cycle.
// Ports: EX_* execute-stage result and qualifiers; STALL/FLUSH pipeline control;
//        WR_VALID/WR_DATA/WR_MASK masked direct write; FLAG_OUT committed flags,
//        FLAG_FWD forwarded flags, FLAGS_PENDING pending occupancy, UPD_CNT commit count.
module nzcv_flag_reg
    import cpu_flags_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EX_VALID,
    input  logic              EX_SET_FLAGS,
    input  logic              EX_COND_MATCH,
    input  logic [1:0]        EX_OP_CLASS,
    input  logic [DATA_W-1:0] EX_RESULT,
    input  logic              EX_ALU_C,
    input  logic              EX_ALU_V,
    input  logic              EX_SHIFT_C,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              WR_VALID,
    input  logic [3:0]        WR_DATA,
    input  logic [3:0]        WR_MASK,
    output logic [3:0]        FLAG_OUT,
    output logic [3:0]        FLAG_FWD,
    output logic              FLAGS_PENDING,
    output logic [CNT_W-1:0]  UPD_CNT
);

    pend_state_e       state_q, state_d;
    logic [3:0]        pend_q;
    logic [3:0]        flag_out_q, flag_out_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        calc_flags;
    logic              accept;
    logic              load_pend;
    logic              commit;

    // FLAG_FWD depends only on registers, so the condition checker can use it
    // to form EX_COND_MATCH without a combinational loop.
    assign FLAG_FWD      = (state_q == PEND_FULL) ? pend_q : flag_out_q;
    assign FLAG_OUT      = flag_out_q;
    assign FLAGS_PENDING = (state_q == PEND_FULL);
    assign UPD_CNT       = cnt_q;

    assign accept = EX_VALID & EX_SET_FLAGS & EX_COND_MATCH &
                    (EX_OP_CLASS != OPC_NONE) & ~STALL & ~FLUSH;

    // Kept bits come from the forwarded view so a back-to-back instruction
    // inherits C/V from the still-uncommitted predecessor.
    nzcv_calc #(.DATA_W(DATA_W)) u_calc (
        .result     (EX_RESULT),
        .op_class   (EX_OP_CLASS),
        .alu_c      (EX_ALU_C),
        .alu_v      (EX_ALU_V),
        .shift_c    (EX_SHIFT_C),
        .keep_cv    ({FLAG_FWD[FLAG_C], FLAG_FWD[FLAG_V]}),
        .next_flags (calc_flags)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= PEND_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_pend = 1'b0;
        commit    = 1'b0;
        case (state_q)
            PEND_EMPTY: begin
                if (accept) begin
                    state_d   = PEND_FULL;
                    load_pend = 1'b1;
                end
            end
            PEND_FULL: begin
                if (FLUSH) begin
                    state_d = PEND_EMPTY;
                end else if (!STALL) begin
                    commit = 1'b1;
                    if (accept) begin
                        load_pend = 1'b1;
                    end else begin
                        state_d = PEND_EMPTY;
                    end
                end
            end
            default: begin
                state_d = PEND_EMPTY;
            end
        endcase
    end

    // Direct write is applied after the commit so it wins per masked bit.
    always_comb begin
        flag_out_d = commit ? pend_q : flag_out_q;
        if (WR_VALID) begin
            flag_out_d = merge_masked(flag_out_d, WR_DATA, WR_MASK);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q     <= 4'b0000;
            flag_out_q <= 4'b0000;
            cnt_q      <= '0;
        end else begin
            if (load_pend) begin
                pend_q <= calc_flags;
            end
            flag_out_q <= flag_out_d;
            if (commit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nzcv_flag_reg.sv
// Purpose: self-checking bench for nzcv_flag_reg (directed table, corner sequences, random vs model).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: STALL/FLUSH driven directly from stimulus.
module tb_nzcv_flag_reg;

    logic        CLK;
    logic        RST_N;
    logic        ex_valid, ex_set_flags, ex_cond_match;
    logic [1:0]  ex_op_class;
    logic [31:0] ex_result;
    logic        ex_alu_c, ex_alu_v, ex_shift_c;
    logic        stall, flush;
    logic        wr_valid;
    logic [3:0]  wr_data, wr_mask;

    logic [3:0]  flag_out, flag_fwd, flag_out2, flag_fwd2;
    logic        flags_pending, flags_pending2;
    logic [7:0]  upd_cnt;
    logic [1:0]  upd_cnt2;

    int checks = 0;
    int errors = 0;

    nzcv_flag_reg #(.DATA_W(32), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .EX_VALID(ex_valid), .EX_SET_FLAGS(ex_set_flags), .EX_COND_MATCH(ex_cond_match),
        .EX_OP_CLASS(ex_op_class), .EX_RESULT(ex_result),
        .EX_ALU_C(ex_alu_c), .EX_ALU_V(ex_alu_v), .EX_SHIFT_C(ex_shift_c),
        .STALL(stall), .FLUSH(flush),
        .WR_VALID(wr_valid), .WR_DATA(wr_data), .WR_MASK(wr_mask),
        .FLAG_OUT(flag_out), .FLAG_FWD(flag_fwd),
        .FLAGS_PENDING(flags_pending), .UPD_CNT(upd_cnt)
    );

    // Narrow-counter instance driven by the same stimulus for saturation checks.
    nzcv_flag_reg #(.DATA_W(32), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N),
        .EX_VALID(ex_valid), .EX_SET_FLAGS(ex_set_flags), .EX_COND_MATCH(ex_cond_match),
        .EX_OP_CLASS(ex_op_class), .EX_RESULT(ex_result),
        .EX_ALU_C(ex_alu_c), .EX_ALU_V(ex_alu_v), .EX_SHIFT_C(ex_shift_c),
        .STALL(stall), .FLUSH(flush),
        .WR_VALID(wr_valid), .WR_DATA(wr_data), .WR_MASK(wr_mask),
        .FLAG_OUT(flag_out2), .FLAG_FWD(flag_fwd2),
        .FLAGS_PENDING(flags_pending2), .UPD_CNT(upd_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [3:0] e_fwd,
                           input logic e_pend, input int e_cnt, input int e_cnt2);
        chk({tag, " flag_out"}, int'(flag_out), int'(e_out));
        chk({tag, " flag_fwd"}, int'(flag_fwd), int'(e_fwd));
        chk({tag, " pending"}, int'(flags_pending), int'(e_pend));
        chk({tag, " upd_cnt"}, int'(upd_cnt), e_cnt);
        chk({tag, " upd_cnt2"}, int'(upd_cnt2), e_cnt2);
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_set_flags = 0; ex_cond_match = 0; ex_op_class = 2'b00;
        ex_result = 32'h0; ex_alu_c = 0; ex_alu_v = 0; ex_shift_c = 0;
        stall = 0; flush = 0; wr_valid = 0; wr_data = 4'h0; wr_mask = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic        vld, sf, cm;
        logic [1:0]  opc;
        logic [31:0] res;
        logic        ac, av, sc, st, fl, wv;
        logic [3:0]  wd, wm;
        logic [3:0]  e_out, e_fwd;
        logic        e_pend;
        logic [7:0]  e_cnt;
        logic [1:0]  e_cnt2;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];

    function automatic vec_t mk(input logic vld, input logic sf, input logic cm, input logic [1:0] opc,
                                input logic [31:0] res, input logic ac, input logic av, input logic sc,
                                input logic st, input logic fl, input logic wv, input logic [3:0] wd,
                                input logic [3:0] wm, input logic [3:0] e_out, input logic [3:0] e_fwd,
                                input logic e_pend, input logic [7:0] e_cnt, input logic [1:0] e_cnt2);
        vec_t v;
        v.vld = vld; v.sf = sf; v.cm = cm; v.opc = opc; v.res = res;
        v.ac = ac; v.av = av; v.sc = sc; v.st = st; v.fl = fl; v.wv = wv;
        v.wd = wd; v.wm = wm; v.e_out = e_out; v.e_fwd = e_fwd;
        v.e_pend = e_pend; v.e_cnt = e_cnt; v.e_cnt2 = e_cnt2;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Pending stage modelled as a queue holding at most one NZCV word.
    logic [3:0] mq[$];
    logic [3:0] m_out;
    int         m_commits;

    function automatic logic [3:0] m_fwd();
        return (mq.size() != 0) ? mq[0] : m_out;
    endfunction

    function automatic logic [3:0] m_calc(input logic [1:0] opc, input logic [31:0] res,
                                          input logic ac, input logic av, input logic sc,
                                          input logic [3:0] prev);
        logic n, z, c, v;
        n = (res >= 32'h8000_0000);
        z = (res == 32'd0);
        c = prev[1];
        v = prev[0];
        if (opc == 2'd0) begin c = ac; v = av; end
        else if (opc == 2'd1) c = sc;
        return {n, z, c, v};
    endfunction

    task automatic m_step();
        logic       acc, cmt;
        logic [3:0] nf;
        acc = ex_valid && ex_set_flags && ex_cond_match && ex_op_class != 2'd3 && !stall && !flush;
        nf  = m_calc(ex_op_class, ex_result, ex_alu_c, ex_alu_v, ex_shift_c, m_fwd());
        cmt = (mq.size() != 0) && !stall && !flush;
        if (cmt) begin
            m_out = mq.pop_front();
            m_commits++;
        end
        if (wr_valid)
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) m_out[b] = wr_data[b];
        if (flush) mq.delete();
        if (acc) mq.push_back(nf);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        vt[0]  = mk(1,1,1,2'd0,32'h0000_0000,1,0,0, 0,0,0,4'h0,4'h0, 4'b0000,4'b0110,1,8'd0,2'd0);
        vt[1]  = mk(0,0,0,2'd0,32'h0,        0,0,0, 0,0,0,4'h0,4'h0, 4'b0110,4'b0110,0,8'd1,2'd1);
        vt[2]  = mk(1,1,1,2'd0,32'h8000_0000,0,1,0, 0,0,0,4'h0,4'h0, 4'b0110,4'b1001,1,8'd1,2'd1);
        vt[3]  = mk(1,1,1,2'd1,32'h0000_0001,0,0,1, 0,0,0,4'h0,4'h0, 4'b1001,4'b0011,1,8'd2,2'd2);
        vt[4]  = mk(0,0,0,2'd0,32'h0,        0,0,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b0011,0,8'd3,2'd3);
        vt[5]  = mk(1,1,0,2'd0,32'h0,        1,1,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b0011,0,8'd3,2'd3);
        vt[6]  = mk(1,0,1,2'd0,32'h0,        1,1,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b0011,0,8'd3,2'd3);
        vt[7]  = mk(1,1,1,2'd3,32'h0,        1,1,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b0011,0,8'd3,2'd3);
        vt[8]  = mk(1,1,1,2'd0,32'h0,        0,0,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b0100,1,8'd3,2'd3);
        vt[9]  = mk(1,1,1,2'd0,32'h1234_5678,1,1,1, 1,0,0,4'h0,4'h0, 4'b0011,4'b0100,1,8'd3,2'd3);
        vt[10] = mk(1,1,1,2'd0,32'h1234_5678,1,1,1, 1,0,0,4'h0,4'h0, 4'b0011,4'b0100,1,8'd3,2'd3);
        vt[11] = mk(1,1,1,2'd0,32'h1234_5678,1,1,1, 1,0,0,4'h0,4'h0, 4'b0011,4'b0100,1,8'd3,2'd3);
        vt[12] = mk(1,1,1,2'd0,32'h1234_5678,1,1,1, 0,1,0,4'h0,4'h0, 4'b0011,4'b0011,0,8'd3,2'd3);
        vt[13] = mk(1,1,1,2'd0,32'h8000_0000,1,0,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b1010,1,8'd3,2'd3);
        vt[14] = mk(0,0,0,2'd0,32'h0,        0,0,0, 0,0,1,4'h1,4'h3, 4'b1001,4'b1001,0,8'd4,2'd3);
        vt[15] = mk(1,1,1,2'd0,32'h0000_0005,0,0,0, 0,0,0,4'h0,4'h0, 4'b1001,4'b0000,1,8'd4,2'd3);
        vt[16] = mk(0,0,0,2'd0,32'h0,        0,0,0, 1,0,1,4'h4,4'h4, 4'b1101,4'b0000,1,8'd4,2'd3);
        vt[17] = mk(0,0,0,2'd0,32'h0,        0,0,0, 0,0,0,4'h0,4'h0, 4'b0000,4'b0000,0,8'd5,2'd3);
        vt[18] = mk(1,1,1,2'd0,32'h0000_0007,1,1,0, 0,0,0,4'h0,4'h0, 4'b0000,4'b0011,1,8'd5,2'd3);
        vt[19] = mk(1,1,1,2'd2,32'h8000_0000,0,0,0, 0,0,0,4'h0,4'h0, 4'b0011,4'b1011,1,8'd6,2'd3);
        vt[20] = mk(0,0,0,2'd0,32'h0,        0,0,0, 0,0,0,4'h0,4'h0, 4'b1011,4'b1011,0,8'd7,2'd3);

        RST_N = 1'b1;
        do_reset();
        chk_all("reset", 4'b0000, 4'b0000, 1'b0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            ex_valid = vt[i].vld; ex_set_flags = vt[i].sf; ex_cond_match = vt[i].cm;
            ex_op_class = vt[i].opc; ex_result = vt[i].res;
            ex_alu_c = vt[i].ac; ex_alu_v = vt[i].av; ex_shift_c = vt[i].sc;
            stall = vt[i].st; flush = vt[i].fl;
            wr_valid = vt[i].wv; wr_data = vt[i].wd; wr_mask = vt[i].wm;
            @(posedge CLK);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].e_out, vt[i].e_fwd, vt[i].e_pend,
                    int'(vt[i].e_cnt), int'(vt[i].e_cnt2));
        end

        // Asynchronous reset mid-cycle with a pending entry in flight.
        idle_inputs();
        ex_valid = 1; ex_set_flags = 1; ex_cond_match = 1; ex_result = 32'h8000_0000;
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 4'b0000, 1'b0, 0, 0);
        idle_inputs();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        chk_all("reset_held", 4'b0000, 4'b0000, 1'b0, 0, 0);

        // Five back-to-back accepts, then drain: narrow counter 1,2,3,3,3.
        ex_valid = 1; ex_set_flags = 1; ex_cond_match = 1; ex_op_class = 2'd0;
        for (int k = 0; k < 6; k++) begin
            ex_result = 32'(k + 1);
            if (k == 5) ex_valid = 0;
            @(posedge CLK);
            #1;
            if (k > 0) begin
                chk($sformatf("sat cnt2 step%0d", k), int'(upd_cnt2), sat(k, 3));
                chk($sformatf("sat cnt step%0d", k), int'(upd_cnt), k);
                chk($sformatf("sat out step%0d", k), int'(flag_out), 0);
            end
            chk($sformatf("sat pend step%0d", k), int'(flags_pending), (k < 5) ? 1 : 0);
        end

        // Randomized run against the queue model.
        do_reset();
        mq.delete();
        m_out = 4'b0000;
        m_commits = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_set_flags  = ($urandom_range(0, 3) != 0);
            ex_cond_match = ($urandom_range(0, 4) != 0);
            ex_op_class   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ex_result = 32'h0;
                1:       ex_result = 32'h8000_0000;
                default: ex_result = $urandom;
            endcase
            ex_alu_c   = 1'($urandom_range(0, 1));
            ex_alu_v   = 1'($urandom_range(0, 1));
            ex_shift_c = 1'($urandom_range(0, 1));
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            wr_valid   = ($urandom_range(0, 7) == 0);
            wr_data    = 4'($urandom_range(0, 15));
            wr_mask    = 4'($urandom_range(0, 15));
            m_step();
            @(posedge CLK);
            #1;
            chk_all("rand", m_out, m_fwd(), (mq.size() != 0), sat(m_commits, 255), sat(m_commits, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
